// File: rtl/tlb_op_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tlb_op_ctrl_pkg: shared encodings for the TLB maintenance-op sequencer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package tlb_op_ctrl_pkg;

    localparam logic [2:0] TLBOP_SRCH = 3'd0;
    localparam logic [2:0] TLBOP_RD   = 3'd1;
    localparam logic [2:0] TLBOP_WR   = 3'd2;
    localparam logic [2:0] TLBOP_FILL = 3'd3;
    localparam logic [2:0] TLBOP_INV  = 3'd4;

    localparam logic [4:0] INVTLB_MAX_TYPE = 5'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SRCH_REQ  = 3'd1,
        ST_SRCH_WAIT = 3'd2,
        ST_EXEC      = 3'd3,
        ST_DONE      = 3'd4
    } tlb_state_e;

    // Right-shift Galois masks for maximal-length LFSRs of width 1..5.
    function automatic logic [4:0] lfsr_taps(input int idxw);
        case (idxw)
            1:       return 5'h01;
            2:       return 5'h03;
            3:       return 5'h06;
            4:       return 5'h0C;
            default: return 5'h14;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_rand_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tlb_rand_gen: TLBFILL replacement index; wrapping counter, or a Galois     |
// | LFSR when TLB_LFSR_RAND_EN is defined. Holds its value while frozen.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tlb_rand_gen
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLBNUM = 32,
    parameter int IDXW   = 5
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            freeze_i,
    output logic [IDXW-1:0] rand_o
);

    logic [IDXW-1:0] rand_q;
    logic [IDXW-1:0] rand_d;
    logic [IDXW-1:0] step_w;

`ifdef TLB_LFSR_RAND_EN
    localparam logic [4:0]      TAPS_ALL = lfsr_taps(IDXW);
    localparam logic [IDXW-1:0] TAPS     = TAPS_ALL[IDXW-1:0];
    localparam logic [IDXW-1:0] SEED     = IDXW'(1);

    assign step_w = rand_q[0] ? ((rand_q >> 1) ^ TAPS) : (rand_q >> 1);
`else
    localparam logic [IDXW-1:0] SEED = '0;
    localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM - 1);

    assign step_w = (rand_q == LAST) ? '0 : rand_q + IDXW'(1);
`endif

    assign rand_d = freeze_i ? rand_q : step_w;
    assign rand_o = rand_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rand_q <= SEED;
        end else begin
            rand_q <= rand_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tlb_op_ctrl: sequences TLBSRCH/RD/WR/FILL/INVTLB one at a time, shares the |
// | s1 search port with the LSU. Optional macro: TLB_LFSR_RAND_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLBNUM = 32,
    parameter int IDXW   = 5
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic [4:0]      op_inv_type,
    input  logic [9:0]      op_inv_asid,
    input  logic [18:0]     op_inv_vpn,
    input  logic [31:0]     csr_tlbehi,
    input  logic            mem_req,
    input  logic [31:0]     mem_vaddr,
    output logic            mem_gnt,
    output logic            s1_fetch,
    output logic [31:0]     s1_vaddr,
    input  logic            s1_found,
    input  logic [IDXW-1:0] s1_index,
    output logic            tlbwr_en,
    output logic            tlbfill_en,
    output logic [IDXW-1:0] rand_index,
    output logic            invtlb_en,
    output logic [4:0]      invtlb_op,
    output logic [9:0]      invtlb_asid,
    output logic [18:0]     invtlb_vpn,
    output logic            srch_we,
    output logic            srch_found,
    output logic [IDXW-1:0] srch_index,
    output logic            rd_we,
    output logic            done,
    output logic            op_err,
    output logic            refetch
);

    tlb_state_e  state_q;
    logic        op_ready_q;
    logic        srch_we_q;
    logic        rd_we_q;
    logic        tlbwr_q;
    logic        tlbfill_q;
    logic        invtlb_en_q;
    logic [4:0]  invtlb_op_q;
    logic [9:0]  invtlb_asid_q;
    logic [18:0] invtlb_vpn_q;
    logic        done_q;
    logic        err_q;
    logic        refetch_q;
    logic        in_idle_w;
    logic        in_srch_req_w;
    logic        unused_w;

    assign unused_w = ^csr_tlbehi[12:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            op_ready_q    <= 1'b1;
            srch_we_q     <= 1'b0;
            rd_we_q       <= 1'b0;
            tlbwr_q       <= 1'b0;
            tlbfill_q     <= 1'b0;
            invtlb_en_q   <= 1'b0;
            invtlb_op_q   <= '0;
            invtlb_asid_q <= '0;
            invtlb_vpn_q  <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            refetch_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle: cleared unless set on a transition below.
            srch_we_q     <= 1'b0;
            rd_we_q       <= 1'b0;
            tlbwr_q       <= 1'b0;
            tlbfill_q     <= 1'b0;
            invtlb_en_q   <= 1'b0;
            invtlb_op_q   <= '0;
            invtlb_asid_q <= '0;
            invtlb_vpn_q  <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            refetch_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        op_ready_q <= 1'b0;
                        if (op_code == TLBOP_SRCH) begin
                            state_q <= ST_SRCH_REQ;
                        end else begin
                            state_q <= ST_EXEC;
                            done_q  <= 1'b1;
                            case (op_code)
                                TLBOP_RD: rd_we_q <= 1'b1;
                                TLBOP_WR: begin
                                    tlbwr_q   <= 1'b1;
                                    refetch_q <= 1'b1;
                                end
                                TLBOP_FILL: begin
                                    tlbfill_q <= 1'b1;
                                    refetch_q <= 1'b1;
                                end
                                TLBOP_INV: begin
                                    if (op_inv_type <= INVTLB_MAX_TYPE) begin
                                        invtlb_en_q   <= 1'b1;
                                        invtlb_op_q   <= op_inv_type;
                                        invtlb_asid_q <= op_inv_asid;
                                        invtlb_vpn_q  <= op_inv_vpn;
                                        refetch_q     <= 1'b1;
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                                default: err_q <= 1'b1;
                            endcase
                        end
                    end
                end
                ST_SRCH_REQ: begin
                    state_q   <= ST_SRCH_WAIT;
                    srch_we_q <= 1'b1;
                    done_q    <= 1'b1;
                end
                ST_SRCH_WAIT: begin
                    state_q    <= ST_IDLE;
                    op_ready_q <= 1'b1;
                end
                ST_EXEC: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    op_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    op_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_idle_w     = (state_q == ST_IDLE);
    assign in_srch_req_w = (state_q == ST_SRCH_REQ);

    // The LSU only sees the port in IDLE; TLBSRCH owns it for one cycle.
    assign mem_gnt  = in_idle_w & mem_req;
    assign s1_fetch = mem_gnt | in_srch_req_w;
    assign s1_vaddr = in_srch_req_w ? {csr_tlbehi[31:13], 13'b0} :
                      (mem_gnt ? mem_vaddr : 32'b0);

    // Search result arrives the cycle after the strobe, i.e. in SRCH_WAIT.
    assign srch_found = srch_we_q & s1_found;
    assign srch_index = srch_we_q ? s1_index : '0;

    assign op_ready    = op_ready_q;
    assign srch_we     = srch_we_q;
    assign rd_we       = rd_we_q;
    assign tlbwr_en    = tlbwr_q;
    assign tlbfill_en  = tlbfill_q;
    assign invtlb_en   = invtlb_en_q;
    assign invtlb_op   = invtlb_op_q;
    assign invtlb_asid = invtlb_asid_q;
    assign invtlb_vpn  = invtlb_vpn_q;
    assign done        = done_q;
    assign op_err      = err_q;
    assign refetch     = refetch_q;

    tlb_rand_gen #(
        .TLBNUM (TLBNUM),
        .IDXW   (IDXW)
    ) u_rand_gen (
        .clk      (clk),
        .resetn   (resetn),
        .freeze_i (tlbfill_q),
        .rand_o   (rand_index)
    );

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tlb_op_ctrl: self-checking bench for tlb_op_ctrl (counter build).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tlb_op_ctrl;

    localparam int IDXW = 5;

    logic            clk;
    logic            resetn;
    logic            op_valid;
    logic            op_ready;
    logic [2:0]      op_code;
    logic [4:0]      op_inv_type;
    logic [9:0]      op_inv_asid;
    logic [18:0]     op_inv_vpn;
    logic [31:0]     csr_tlbehi;
    logic            mem_req;
    logic [31:0]     mem_vaddr;
    logic            mem_gnt;
    logic            s1_fetch;
    logic [31:0]     s1_vaddr;
    logic            s1_found;
    logic [IDXW-1:0] s1_index;
    logic            tlbwr_en;
    logic            tlbfill_en;
    logic [IDXW-1:0] rand_index;
    logic            invtlb_en;
    logic [4:0]      invtlb_op;
    logic [9:0]      invtlb_asid;
    logic [18:0]     invtlb_vpn;
    logic            srch_we;
    logic            srch_found;
    logic [IDXW-1:0] srch_index;
    logic            rd_we;
    logic            done;
    logic            op_err;
    logic            refetch;

    tlb_op_ctrl #(.TLBNUM(32), .IDXW(IDXW)) dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_inv_type(op_inv_type), .op_inv_asid(op_inv_asid), .op_inv_vpn(op_inv_vpn),
        .csr_tlbehi(csr_tlbehi), .mem_req(mem_req), .mem_vaddr(mem_vaddr),
        .mem_gnt(mem_gnt), .s1_fetch(s1_fetch), .s1_vaddr(s1_vaddr),
        .s1_found(s1_found), .s1_index(s1_index),
        .tlbwr_en(tlbwr_en), .tlbfill_en(tlbfill_en), .rand_index(rand_index),
        .invtlb_en(invtlb_en), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
        .invtlb_vpn(invtlb_vpn), .srch_we(srch_we), .srch_found(srch_found),
        .srch_index(srch_index), .rd_we(rd_we), .done(done), .op_err(op_err),
        .refetch(refetch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Translation-unit model: hit when VA[31:20]==0x123, index = VA[17:13]^4.
    always @(posedge clk) begin
        s1_found <= s1_fetch && (s1_vaddr[31:20] == 12'h123);
        s1_index <= s1_vaddr[17:13] ^ 5'd4;
    end

    // Reference replacement counter; the bench freezes it itself during a FILL.
    logic       model_freeze;
    logic [4:0] m_rand;
    always @(posedge clk or negedge resetn) begin
        if (!resetn)            m_rand <= 5'd0;
        else if (!model_freeze) m_rand <= m_rand + 5'd1;
    end

    // flags = {rd, wr, fill, inv, err, refetch, srch_we, srch_found}
    typedef struct {
        logic [2:0]  code;
        logic [4:0]  itype;
        logic [9:0]  asid;
        logic [18:0] vpn;
        logic [31:0] ehi;
        logic [7:0]  flags;
        logic [4:0]  sidx;
        int          lat;
    } vec_t;

    typedef struct {
        logic [46:0] outs;
        int          lat;
        logic        fill;
    } exp_t;

    exp_t sb[$];
    vec_t vt[11];
    int   total;
    int   bad;

    logic [46:0] act_outs;
    assign act_outs = {rd_we, tlbwr_en, tlbfill_en, invtlb_en, op_err, refetch,
                       srch_we, srch_found, srch_index, invtlb_op, invtlb_asid, invtlb_vpn};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!op_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!op_ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_done(input string nm, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_outs"}, 64'(act_outs), 64'(e.outs));
        chk({nm, "_lat"}, 64'(lat), 64'(e.lat));
        if (e.fill) chk({nm, "_rand"}, 64'(rand_index), 64'(m_rand));
    endtask

    task automatic do_op(input string nm, input vec_t v);
        exp_t e;
        bit   seen;
        wait_ready();
        op_valid    = 1'b1;
        op_code     = v.code;
        op_inv_type = v.itype;
        op_inv_asid = v.asid;
        op_inv_vpn  = v.vpn;
        csr_tlbehi  = v.ehi;
        e.outs = {v.flags, v.sidx, (v.flags[4] ? {v.itype, v.asid, v.vpn} : 34'd0)};
        e.lat  = v.lat;
        e.fill = v.flags[5];
        sb.push_back(e);
        @(posedge clk); #1;
        op_valid     = 1'b0;
        model_freeze = (v.code == 3'd3);
        seen = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1 && v.code == 3'd0) begin
                chk({nm, "_fetch"}, 64'(s1_fetch), 64'd1);
                chk({nm, "_vaddr"}, 64'(s1_vaddr), 64'(v.ehi & 32'hFFFF_E000));
            end
            if (done) begin
                check_done(nm, c);
                seen = 1;
            end
            @(posedge clk); #1;
            model_freeze = 1'b0;
            if (seen) break;
        end
        if (!seen) begin
            chk({nm, "_done_timeout"}, 64'd0, 64'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t fv;
        int   n;
        total = 0;
        bad   = 0;
        //            code  itype  asid    vpn        ehi           flags         sidx   lat
        vt[0]  = '{3'd0, 5'd0, 10'h0,  19'h0,     32'h1234_6000, 8'b0000_0011, 5'd7,  2};
        vt[1]  = '{3'd0, 5'd0, 10'h0,  19'h0,     32'h00AB_E123, 8'b0000_0010, 5'h1B, 2};
        vt[2]  = '{3'd0, 5'd0, 10'h0,  19'h0,     32'h1237_A000, 8'b0000_0011, 5'h19, 2};
        vt[3]  = '{3'd1, 5'd0, 10'h0,  19'h0,     32'h0,         8'b1000_0000, 5'd0,  1};
        vt[4]  = '{3'd2, 5'd0, 10'h0,  19'h0,     32'h0,         8'b0100_0100, 5'd0,  1};
        vt[5]  = '{3'd3, 5'd0, 10'h0,  19'h0,     32'h0,         8'b0010_0100, 5'd0,  1};
        vt[6]  = '{3'd4, 5'd5, 10'h3A, 19'h1ABCD, 32'h0,         8'b0001_0100, 5'd0,  1};
        vt[7]  = '{3'd4, 5'd7, 10'h3A, 19'h1ABCD, 32'h0,         8'b0000_1000, 5'd0,  1};
        vt[8]  = '{3'd4, 5'd6, 10'h155,19'h7FFFF, 32'h0,         8'b0001_0100, 5'd0,  1};
        vt[9]  = '{3'd4, 5'd0, 10'h3FF,19'h00001, 32'h0,         8'b0001_0100, 5'd0,  1};
        vt[10] = '{3'd5, 5'd0, 10'h0,  19'h0,     32'h0,         8'b0000_1000, 5'd0,  1};

        resetn = 1'b0; op_valid = 1'b0; op_code = 3'd0; op_inv_type = 5'd0;
        op_inv_asid = 10'd0; op_inv_vpn = 19'd0; csr_tlbehi = 32'd0;
        mem_req = 1'b0; mem_vaddr = 32'd0; model_freeze = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 64'(op_ready), 64'd1);
        chk("rst_outs", 64'(act_outs), 64'd0);
        chk("rst_misc", 64'({mem_gnt, s1_fetch, s1_vaddr, done}), 64'd0);
        chk("rst_rand", 64'(rand_index), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) do_op($sformatf("vec%0d", i), vt[i]);
        fv = vt[10];
        fv.code = 3'd7;
        do_op("op7", fv);

        // FILL presented while the replacement index is 13
        n = 0;
        while (m_rand != 5'd12 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        do_op("fill13", vt[5]);
        @(negedge clk);
        chk("fill13_hold", 64'(rand_index), 64'd13);
        @(posedge clk);
        @(negedge clk);
        chk("fill13_next", 64'(rand_index), 64'd14);
        @(posedge clk); #1;

        // LSU request held across a search and a write
        wait_ready();
        mem_req = 1'b1; mem_vaddr = 32'hDEAD_B000; csr_tlbehi = 32'h1234_6000;
        @(negedge clk);
        chk("lsu_idle_gnt", 64'(mem_gnt), 64'd1);
        chk("lsu_idle_vaddr", 64'(s1_vaddr), 64'hDEAD_B000);
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = 3'd0;
        @(negedge clk);
        chk("lsu_simul_gnt", 64'(mem_gnt), 64'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("lsu_req_gnt", 64'(mem_gnt), 64'd0);
        chk("lsu_req_vaddr", 64'(s1_vaddr), 64'h1234_6000);
        @(posedge clk);
        @(negedge clk);
        chk("lsu_wait_gnt", 64'(mem_gnt), 64'd0);
        chk("lsu_wait_res", 64'({done, srch_we, srch_found, srch_index}), 64'({3'b111, 5'd7}));
        @(posedge clk);
        @(negedge clk);
        chk("lsu_back_gnt", 64'(mem_gnt), 64'd1);
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = 3'd2;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("lsu_exec_gnt", 64'({mem_gnt, tlbwr_en}), 64'b01);
        @(posedge clk);
        @(negedge clk);
        chk("lsu_done_gnt", 64'({mem_gnt, op_ready, done, tlbwr_en}), 64'b0000);
        @(posedge clk);
        @(negedge clk);
        chk("lsu_back2_gnt", 64'({mem_gnt, op_ready}), 64'b11);
        @(posedge clk); #1;
        mem_req = 1'b0;

        // Reset while the search result is being returned
        wait_ready();
        csr_tlbehi = 32'h1234_6000;
        op_valid = 1'b1; op_code = 3'd0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_we_before", 64'({srch_we, done}), 64'b11);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_strobes", 64'({srch_we, done, srch_found}), 64'd0);
        chk("mid_rst_ready", 64'(op_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("mid_release_ready", 64'(op_ready), 64'd1);
        chk("mid_release_outs", 64'({act_outs, done}), 64'd0);
        chk("mid_release_rand", 64'(rand_index), 64'(m_rand));
        @(posedge clk); #1;
        do_op("post_rst_rd", vt[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
